swizzle_pipe: RTL and testbench

- Parametrised, pipelined bit-permutation unit; next generation of the fixed bit-reverse swizzle microbenchmark.
- Adds four runtime-selectable permutation modes, configurable pipeline depth, valid/ready flow control with full backpressure, and a completed-transaction counter.
- Used as a microbenchmark DUT driven by a ROM-based test harness, and as a reusable datapath block.

---
 rtl/swizzle_pkg.sv | 15 +
 rtl/swizzle_perm.sv | 66 ++++++
 rtl/swizzle_pipe.sv | 171 +++++++++++++++++
 tb/tb_swizzle_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/swizzle_pkg.sv
// Shared types and constants for the swizzle_pipe bit-permutation unit.
package swizzle_pkg;

    // Runtime permutation select; encoding matches the in_mode port.
    typedef enum logic [1:0] {
        SWZ_BITREV,
        SWZ_GRPREV,
        SWZ_ROTL,
        SWZ_PASS
    } swz_mode_e;

    // Width of the completed-transaction counter.
    localparam int COUNT_W = 16;

endpackage

// File: rtl/swizzle_perm.sv
// Purely combinational bit permutation: bit reverse, group reverse,
// rotate-left (amount reduced mod WIDTH) or pass-through.
module swizzle_perm
    import swizzle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  swz_mode_e        mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] result
);

    localparam int NGRP = WIDTH / GROUP;

    genvar gi;

    // Reject configurations the permutations are not defined for.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("swizzle_perm: WIDTH must be >= 2");
        end
        if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_bad_group
            $error("swizzle_perm: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    logic [WIDTH-1:0]   rev_w;
    logic [WIDTH-1:0]   grp_w;
    logic [WIDTH-1:0]   rot_w;
    logic [31:0]        amt_ext;
    logic [31:0]        eff_amt;
    logic [2*WIDTH-1:0] rot_ext;

    // Bit reverse and group reverse are pure wiring.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign rev_w[gi] = data[WIDTH-1-gi];
            assign grp_w[gi] = data[(NGRP-1-(gi/GROUP))*GROUP + (gi%GROUP)];
        end
    endgenerate

    // Rotate: shift a doubled copy and keep the upper half; the modulo
    // handles amounts >= WIDTH when WIDTH is not a power of two.
    always_comb begin
        amt_ext = {{(32-AMT_W){1'b0}}, amt};
        eff_amt = amt_ext % WIDTH;
        rot_ext = {data, data} << eff_amt;
        rot_w   = rot_ext[2*WIDTH-1:WIDTH];
    end

    // Select the requested permutation.
    always_comb begin
        result = data;
        unique case (mode)
            SWZ_BITREV: result = rev_w;
            SWZ_GRPREV: result = grp_w;
            SWZ_ROTL:   result = rot_w;
            SWZ_PASS:   result = data;
            default:    result = data;
        endcase
    end

endmodule

// File: rtl/swizzle_pipe.sv
// Pipelined bit-permutation unit with valid/ready flow control and a
// completed-output counter. Optional feature macro SWIZZLE_PIPE_PARITY_EN
// adds an out_parity port carried alongside the data.
module swizzle_pipe
    import swizzle_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int GROUP  = 4,
    parameter int STAGES = 2,
    parameter int AMT_W  = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_mode,
    input  logic [AMT_W-1:0]   in_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef SWIZZLE_PIPE_PARITY_EN
    output logic               out_parity,
`endif
    output logic [COUNT_W-1:0] out_count
);

    genvar gi;

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("swizzle_pipe: STAGES must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]   perm_w;
    logic [STAGES-1:0]  stage_valid;
    logic [WIDTH-1:0]   stage_data [STAGES];
    logic [STAGES-1:0]  advance;
    logic               out_fire;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
`ifdef SWIZZLE_PIPE_PARITY_EN
    logic [STAGES-1:0]  stage_par;
`endif

    swizzle_perm #(
        .WIDTH (WIDTH),
        .GROUP (GROUP),
        .AMT_W (AMT_W)
    ) u_perm (
        .data   (in_data),
        .mode   (swz_mode_e'(in_mode)),
        .amt    (in_amt),
        .result (perm_w)
    );

    // A stage may advance if out_ready is high or any stage from it to the
    // tail is empty (closed form of the empty-or-next-advances chain).
    always_comb begin : p_advance
        logic full_tail;
        full_tail = 1'b1;
        advance   = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            full_tail  = full_tail & stage_valid[s];
            advance[s] = out_ready | ~full_tail;
        end
    end

    assign in_ready  = advance[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign out_fire  = out_valid & out_ready;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             src_valid;
            logic [WIDTH-1:0] src_data;
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
`ifdef SWIZZLE_PIPE_PARITY_EN
            logic             src_par;
            logic             par_q;
            logic             par_d;
`endif

            if (gi == 0) begin : g_src_head
                assign src_valid = in_valid;
                assign src_data  = perm_w;
`ifdef SWIZZLE_PIPE_PARITY_EN
                assign src_par   = ^in_data;
`endif
            end else begin : g_src_body
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[gi-1];
`ifdef SWIZZLE_PIPE_PARITY_EN
                assign src_par   = stage_par[gi-1];
`endif
            end

            // On advance take the upstream beat (or bubble); data only
            // loads with a valid beat so the register holds otherwise.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
`ifdef SWIZZLE_PIPE_PARITY_EN
                par_d   = par_q;
`endif
                if (advance[gi]) begin
                    valid_d = src_valid;
                    if (src_valid) begin
                        data_d = src_data;
`ifdef SWIZZLE_PIPE_PARITY_EN
                        par_d  = src_par;
`endif
                    end
                end
            end

            // Stage register; reset clears valid and payload.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
`ifdef SWIZZLE_PIPE_PARITY_EN
                    par_q   <= 1'b0;
`endif
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
`ifdef SWIZZLE_PIPE_PARITY_EN
                    par_q   <= par_d;
`endif
                end
            end

            assign stage_valid[gi] = valid_q;
            assign stage_data[gi]  = data_q;
`ifdef SWIZZLE_PIPE_PARITY_EN
            assign stage_par[gi]   = par_q;
`endif
        end
    endgenerate

    // Count completed output handshakes; wraps naturally.
    always_comb begin
        count_d = count_q + {{(COUNT_W-1){1'b0}}, out_fire};
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;

`ifdef SWIZZLE_PIPE_PARITY_EN
    assign out_parity = stage_par[STAGES-1];

    // Every mode is a permutation, so data parity must match the carried bit.
    a_parity : assert property (@(posedge clock) disable iff (reset)
        (^out_data) == out_parity);
`endif

endmodule

// File: tb/tb_swizzle_pipe.sv
// Scoreboard bench for swizzle_pipe (WIDTH=8, GROUP=4, STAGES=2).
module tb_swizzle_pipe;
    import swizzle_pkg::*;

    localparam int WIDTH  = 8;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;
    localparam int AMT_W  = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [15:0]      out_count;
`ifdef SWIZZLE_PIPE_PARITY_EN
    logic             out_parity;
`endif

    swizzle_pipe #(
        .WIDTH  (WIDTH),
        .GROUP  (GROUP),
        .STAGES (STAGES),
        .AMT_W  (AMT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SWIZZLE_PIPE_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_count (out_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               exp_cnt = 0;
    int               accepted = 0;
    bit               check_lat = 1'b0;
    bit               use_dir = 1'b0;
    logic [WIDTH-1:0] dir_exp;
    logic [WIDTH-1:0] rom [50];

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: arithmetic statement of each mode.
    function automatic logic [WIDTH-1:0] ref_perm(logic [WIDTH-1:0] x, int mode, int amt);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] chunk;
        int               a;
        int               ng;
        r = x;
        case (mode)
            0: for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
            1: begin
                ng = WIDTH / GROUP;
                r  = '0;
                for (int k = 0; k < ng; k++) begin
                    chunk = (x >> (k*GROUP)) & ((1 << GROUP) - 1);
                    r     = r | (chunk << ((ng-1-k)*GROUP));
                end
            end
            2: begin
                a = amt % WIDTH;
                r = (x << a) | (x >> (WIDTH - a));
            end
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    // One clock: record an input handshake at the negedge, return after the next edge.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (!reset && in_valid && in_ready) begin
            e.data = use_dir ? dir_exp : ref_perm(in_data, int'(in_mode), int'(in_amt));
            e.cyc  = cyc;
            sb.push_back(e);
            accepted++;
            $display("IN  cyc=%0d data=%h mode=%0d amt=%0d exp=%h", cyc, in_data, in_mode, in_amt, e.data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            exp_cnt = 0;
        end else if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL spurious_beat: got=%h want=none", out_data);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL out_data: got=%h want=%h", out_data, mon_e.data);
                end
                if (check_lat) chk("latency", cyc - mon_e.cyc, STAGES);
            end
            chk("out_count", out_count, exp_cnt & 16'hFFFF);
            exp_cnt++;
            $display("OUT cyc=%0d data=%h count=%0d", cyc, out_data, out_count);
        end
    end

    logic [WIDTH-1:0] d_data [7] = '{8'h01, 8'hF0, 8'hA5, 8'h3C, 8'h81, 8'h81, 8'h81};
    logic [1:0]       d_mode [7] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
    logic [AMT_W-1:0] d_amt  [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd7, 3'd0};
    logic [WIDTH-1:0] d_exp  [7] = '{8'h80, 8'h0F, 8'h5A, 8'h3C, 8'h03, 8'hC0, 8'h81};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_amt = '0; out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors with fixed expected values.
        use_dir = 1'b1; check_lat = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = d_data[i]; in_mode = d_mode[i]; in_amt = d_amt[i]; dir_exp = d_exp[i];
            step();
        end
        in_valid = 1'b0; use_dir = 1'b0;
        drain();

        // Backpressure: consumer stalled while producer streams 1,2,3,...
        check_lat = 1'b0; out_ready = 1'b0; in_mode = 2'd3; in_amt = '0; accepted = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(accepted + 1);
            step();
        end
        chk("bp_accepted", accepted, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_hold", out_data, 8'h01);
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Streaming 50 ROM vectors in bit-reverse mode from a clean reset.
        reset = 1'b1; sb.delete(); step(); reset = 1'b0;
        for (int i = 0; i < 50; i++) rom[i] = WIDTH'($urandom);
        check_lat = 1'b1; out_ready = 1'b1; in_mode = 2'd0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1; in_data = rom[i];
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("stream_count", out_count, 50);

        // Random modes, amounts and handshakes on both sides.
        check_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_data   = WIDTH'($urandom);
            in_mode   = 2'($urandom);
            in_amt    = AMT_W'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Reset with two beats in flight discards them.
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_valid = 1'b0; reset = 1'b1; sb.delete(); step(); reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        out_ready = 1'b1;
        repeat (5) step();
        chk("midrst_no_stale", out_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
